// File: rtl/commu_pkg.sv
// rtl/commu_pkg.sv - shared types and constants for the conversion-register arbiter
package commu_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/commu_arbiter_rr_pick.sv
// rtl/commu_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] pos;

    // Scan from farthest to nearest after last so the nearest set bit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/commu_arbiter.sv
// rtl/commu_arbiter.sv - round-robin owner of the conversion register load/valid strobes
module commu_arbiter
    import commu_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int HOLD_CYC = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          ext_data,
    output logic                       valid,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("commu_arbiter: HOLD_CYC must be at least 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("commu_arbiter: NUM_REQ must be in 2..8");
    end

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [IDX_W-1:0]   last_q, last_n;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    logic [NUM_REQ-1:0] ack_n;
    logic               wr_en_n, valid_n, busy_n;
    logic [DATA_W-1:0]  data_n;
    logic [IDX_W-1:0]   grant_n;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        last_n  = last_q;
        grant_n = grant_id;
        data_n  = ext_data;
        wr_en_n = 1'b0;
        valid_n = 1'b0;
        ack_n   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = LOAD;
                    grant_n = pick_idx;
                    data_n  = req_data[pick_idx*DATA_W +: DATA_W];
                    wr_en_n = 1'b1;
                end
            end
            LOAD: begin
                state_n = HOLD;
                cnt_n   = '0;
            end
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_n         = DONE;
                    valid_n         = 1'b1;
                    ack_n[grant_id] = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                last_n  = grant_id;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            ack      <= '0;
            wr_en    <= 1'b0;
            ext_data <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            last_q   <= last_n;
            ack      <= ack_n;
            wr_en    <= wr_en_n;
            ext_data <= data_n;
            valid    <= valid_n;
            busy     <= busy_n;
            grant_id <= grant_n;
        end
    end

endmodule

// File: tb/tb_commu_arbiter.sv
// tb/tb_commu_arbiter.sv - directed self-checking bench for commu_arbiter
module tb_commu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req1;
    logic [31:0] req_data, req_data1;
    logic [3:0]  ack, ack1;
    logic        wr_en, wr_en1, valid, valid1, busy, busy1;
    logic [7:0]  ext_data, ext_data1;
    logic [1:0]  grant_id, grant_id1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    commu_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYC(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .wr_en(wr_en), .ext_data(ext_data), .valid(valid), .busy(busy),
        .grant_id(grant_id)
    );

    commu_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYC(1)) dut_h1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .ack(ack1),
        .wr_en(wr_en1), .ext_data(ext_data1), .valid(valid1), .busy(busy1),
        .grant_id(grant_id1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req1      = '0;
        req_data  = '0;
        req_data1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] t2_data [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    int         t3_exp  [4] = '{0, 2, 0, 2};

    initial begin
        // Test 1: single request, latency and reset state
        do_reset();
        chk("rst_ack", ack, 0);           chk("rst_wr_en", wr_en, 0);
        chk("rst_ext_data", ext_data, 0); chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);         chk("rst_grant_id", grant_id, 0);
        chk("rst_h1_busy", busy1, 0);     chk("rst_h1_ack", ack1, 0);
        req_data = 32'h0000A500;
        req      = 4'b0010;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
            chk($sformatf("t1_wr_en_c%0d", c), wr_en, (c == 1));
            chk($sformatf("t1_valid_c%0d", c), valid, (c == 5));
            chk($sformatf("t1_ack_c%0d", c), ack, (c == 5) ? 4'b0010 : 4'b0000);
            chk($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 5));
            chk($sformatf("t1_ext_data_c%0d", c), ext_data, 8'hA5);
            chk($sformatf("t1_grant_id_c%0d", c), grant_id, 1);
        end

        // Test 2: all four requesting, round-robin order and period
        do_reset();
        req_data = 32'h43322110;
        req      = 4'hF;
        for (int c = 1; c <= 24; c++) begin
            int k, ph;
            @(negedge clk);
            k  = (c - 1) / 6;
            ph = (c - 1) % 6;
            chk($sformatf("t2_wr_en_c%0d", c), wr_en, (ph == 0));
            chk($sformatf("t2_ack_c%0d", c), ack, (ph == 4) ? (4'b0001 << k) : 4'b0000);
            if (ph == 0) begin
                chk($sformatf("t2_grant_id_c%0d", c), grant_id, k);
                chk($sformatf("t2_ext_data_c%0d", c), ext_data, t2_data[k]);
            end
            if (ph == 5) req[k] = 1'b0;
        end

        // Test 3: two continuous requesters alternate
        do_reset();
        req_data = 32'h00CC00AA;
        req      = 4'b0101;
        begin
            int g;
            g = 0;
            for (int c = 1; c <= 24; c++) begin
                @(negedge clk);
                if (wr_en) begin
                    if (g < 4) chk($sformatf("t3_grant_%0d", g), grant_id, t3_exp[g]);
                    g++;
                end
            end
            chk("t3_grant_count", g, 4);
        end

        // Test 4: reset mid-HOLD aborts without ack, then RR restarts
        do_reset();
        req_data = 32'h77003300;
        req      = 4'b1000;
        @(negedge clk);
        req = 4'b1010;
        chk("t4_wr_en_c1", wr_en, 1);
        chk("t4_grant_c1", grant_id, 3);
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy_c3", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ack_c4", ack, 0);           chk("t4_wr_en_c4", wr_en, 0);
        chk("t4_ext_data_c4", ext_data, 0); chk("t4_valid_c4", valid, 0);
        chk("t4_busy_c4", busy, 0);         chk("t4_grant_id_c4", grant_id, 0);
        rst = 1'b0;
        for (int c = 5; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("t4_ack_c%0d", c), ack, (c == 9) ? 4'b0010 : 4'b0000);
            chk($sformatf("t4_wr_en_c%0d", c), wr_en, (c == 5));
            if (c == 5) begin
                chk("t4_grant_after_rst", grant_id, 1);
                chk("t4_ext_data_after_rst", ext_data, 8'h33);
            end
        end
        req = '0;

        // Test 5: one-cycle request still completes, byte is held
        do_reset();
        req_data = 32'h005C0000;
        req      = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req      = '0;
                req_data = '0;
                chk("t5_grant_c1", grant_id, 2);
            end
            chk($sformatf("t5_wr_en_c%0d", c), wr_en, (c == 1));
            chk($sformatf("t5_ack_c%0d", c), ack, (c == 5) ? 4'b0100 : 4'b0000);
            chk($sformatf("t5_ext_data_c%0d", c), ext_data, 8'h5C);
        end

        // Test 6: minimum hold time build
        do_reset();
        req_data1 = 32'h000000FF;
        req1      = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req1 = '0;
            chk($sformatf("t6_wr_en_c%0d", c), wr_en1, (c == 1));
            chk($sformatf("t6_valid_c%0d", c), valid1, (c == 3));
            chk($sformatf("t6_ack_c%0d", c), ack1, (c == 3) ? 4'b0001 : 4'b0000);
            chk($sformatf("t6_ext_data_c%0d", c), ext_data1, 8'hFF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/commu_arbiter.md
Name: commu_arbiter

Overview:
Round-robin controller that shares the 8-bit communication conversion register between NUM_REQ requesters. It captures a granted requester's byte and pulses wr_en to load the register. It then waits a programmable hold time and signals transfer complete (valid) to the datapath and ack to the winning requester. It sits between the requester blocks and the conversion register and is the only driver of its wr_en, ext_data and valid inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width carried to the conversion register
HOLD_CYC, 3, clk cycles between the wr_en pulse and completion (>=1, elaboration-time check)

Ports:
clk  in  1  single system clock; the conversion register's commu_clk is tied to clk at integration
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester transfer request, level
req_data  in  NUM_REQ*DATA_W  requester i byte in bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
wr_en  out  1  load strobe to the conversion register
ext_data  out  DATA_W  byte presented to the conversion register
valid  out  1  transfer complete; gates the register output
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester

Behaviour:
- All outputs are registered. Reset values: ack=0, wr_en=0, ext_data=0, valid=0, busy=0, grant_id=0. State=IDLE. RR pointer last=NUM_REQ-1, so req[0] has top priority after reset.
- FSM IDLE -> LOAD -> HOLD -> DONE -> IDLE.
- IDLE: if any req bit is high, pick the first set bit searching from last+1 upward with wrap. Latch grant_id and ext_data <= req_data slice. Next state is LOAD. If no req is high, stay in IDLE.
- LOAD: wr_en=1 for exactly this one cycle; clear the hold counter; go to HOLD.
- HOLD: wr_en=0; count HOLD_CYC cycles; when cnt==HOLD_CYC-1, go to DONE.
- DONE: valid=1 and ack[grant_id]=1 for this one cycle; last <= grant_id; go to IDLE.
- Latency: req sampled high in IDLE at cycle t gives wr_en at t+1 and valid/ack at t+2+HOLD_CYC. Back-to-back transfer period is HOLD_CYC+3 cycles, because one IDLE cycle is mandatory.
- ext_data holds the last transferred byte after DONE and only changes on a grant.
- The requester must hold req_data stable until the grant cycle only; data is captured in IDLE.
- If req drops after the grant, the transfer still completes and the ack is still pulsed. There is no abort.
- If req is still high in the IDLE cycle after ack, it is treated as a new request, subject to round robin.
- Requests arriving while busy are not lost; they are arbitrated at the next IDLE cycle.
- Reset in any state takes effect at the next clk edge: all outputs return to reset values and no ack is issued for the aborted transfer.
- Counter width is $clog2(HOLD_CYC+1). There is no wrap-around beyond HOLD_CYC-1.

Decomposition:
- Package commu_pkg: state enum (IDLE, LOAD, HOLD, DONE) and the default DATA_W constant.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and last; outputs are any and idx.

Test Plan:
1. NUM_REQ=4, HOLD_CYC=3; req[1]=1 with data 0xA5 at cycle 0 -> wr_en high at cycle 1 only, with ext_data=0xA5 and grant_id=1; valid and ack[1] high at cycle 5 only; busy high at cycles 1-5.
2. All four req held high with data 0x10/0x21/0x32/0x43, each requester dropping req the cycle after its ack -> grants in order 0,1,2,3; wr_en at cycles 1,7,13,19; ext_data values 0x10,0x21,0x32,0x43 in that order.
3. req[0] and req[2] re-asserted continuously -> grants alternate 0,2,0,2 and neither is granted twice in a row.
4. Reset asserted at cycle 3 (HOLD) of a req[3] transfer, with req[3] and req[1] both held -> cycle 4 shows all outputs 0; no ack[3] is pulsed; the first grant after reset goes to req[1].
5. req[2] pulsed high for one cycle only, data 0x5C -> the transfer still completes; ack[2] pulses at cycle 5; ext_data stays 0x5C afterwards.
6. HOLD_CYC=1 build, req[0] with data 0xFF -> wr_en at cycle 1; valid and ack[0] at cycle 3.
